alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the 32-bit MIPS ALU: WIDTH-bit datapath, registered outputs, and a Start/Busy/We handshake.
- Single-cycle ops: logic, ADD, SUB, SLT and SLTU.
- Multi-cycle unsigned ops: DIVU and MODU, computed by an iterative restoring divider that shares one WIDTH-bit subtractor.
- Sits in the execute stage; the pipeline control stalls on Busy and writes the register file on We.

Parameters:
- WIDTH, 32, datapath width in bits; legal range 4..64.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  launch an operation; sampled only when Busy=0
- A  input  WIDTH  operand A; captured on an accepted Start
- B  input  WIDTH  operand B; captured on an accepted Start
- ALUOp  input  4  operation select; captured on an accepted Start
- Result  output  WIDTH  registered result; held until the next We
- C  output  1  carry-out of ADD/SUB (SUB: 1 = no borrow)
- Overflow  output  1  signed overflow of ADD/SUB
- Zero  output  1  1 when Result is all zeros
- DivZero  output  1  DIVU/MODU attempted with B=0
- Busy  output  1  multi-cycle op in progress; Start ignored
- We  output  1  one-cycle pulse: Result and flags valid, write-back enabled

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR
  - 0100 SLT (signed), 0101 ADD, 0110 SUB, 0111 MODU, 1000 DIVU, 1001 SLTU
  - 1010-1111 illegal: Result=0, all flags 0, We pulses at 1-cycle latency.
- Reset (sync, active-high): state=IDLE. Result, C, Overflow, Zero, DivZero, Busy and We all =0. Divider registers cleared. Reset overrides Start in the same cycle.
- FSM states: IDLE, DIV.
- IDLE, Start=1, single-cycle op:
  - Result and flags registered at the next edge; We=1 for exactly one cycle; latency 1.
  - Back-to-back Starts every cycle are legal.
- IDLE, Start=1, DIVU/MODU with B≠0:
  - Capture A into quotient shift register Q, B into D; clear remainder R; count=WIDTH.
  - Go to DIV; Busy=1 from the next cycle.
- IDLE, Start=1, DIVU/MODU with B=0:
  - No DIV entry; latency 1; We=1, DivZero=1.
  - DIVU Result = all ones; MODU Result = A.
- DIV, per cycle (one quotient bit):
  - {R,Q} shifted left 1; T = R_shifted − D.
  - If T ≥ 0: R=T and Q[0]=1; else R unchanged and Q[0]=0.
  - count decrements.
  - When count reaches 0: Result = Q (DIVU) or R (MODU); We=1; Busy=0; return to IDLE.
  - Latency from accepted Start to We = WIDTH+1 cycles.
- Busy is deasserted in the We cycle, so a Start in that cycle is accepted.
- Start while Busy=1: ignored, no side effects. A, B and ALUOp may change freely during Busy.
- Arithmetic rules:
  - ADD/SUB use a single WIDTH+1-bit adder; SUB = A + ~B + 1.
  - C = adder bit WIDTH.
  - Overflow = (A[msb]==Bin[msb]) && (Sum[msb]!=A[msb]).
  - SLT: Result = {0…, Sum[msb] XOR Overflow}, which is correct across the overflow boundary (fixes the old sign-bit-only SLT).
  - SLTU: Result = {0…, ~C} of A−B.
  - For all non-ADD/SUB ops: C=0, Overflow=0.
  - DivZero=0 except on the B=0 divide case.
- Zero is computed from the value being written to Result and updated only on We.
- Between We pulses, all outputs hold their values.
- Reset asserted during DIV: abort; divider state discarded; no We.

Optional Feature:
- Macro: ALU_SEQ_FAST_DIV_EN.
- Defined: divider retires 2 quotient bits per cycle (two chained restoring steps, two subtractors). DIV latency = ceil(WIDTH/2)+1 cycles. Odd WIDTH: the final cycle performs one step only. Results are bit-identical to the radix-2 path.
- Undefined: 1 bit/cycle; latency WIDTH+1; single subtractor.

Test Plan:
- WIDTH=32. Reset held 2 cycles, then released -> every output 0. Start=1 with Reset=1 -> no We.
- ADD, A=0xFFFFFFFF, B=0x00000001 -> next cycle: We=1, Result=0, C=1, Zero=1, Overflow=0. ADD, A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1.
- SLT, A=0x80000000, B=0x00000001 -> Result=1. SLTU with the same operands -> Result=0. SUB, A=5, B=7 -> Result=0xFFFFFFFE, C=0.
- DIVU, A=100, B=7:
  - Busy=1 for 32 cycles; We at cycle 33 with Result=14.
  - MODU with the same operands -> Result=2.
  - A Start issued mid-Busy is ignored.
  - A Start in the We cycle is accepted.
  - With ALU_SEQ_FAST_DIV_EN defined: We at cycle 17.
- DIVU, A=0x1234, B=0 -> cycle 1: We=1, DivZero=1, Result=0xFFFFFFFF. MODU, A=0x1234, B=0 -> Result=0x1234.
- DIVU started, Reset pulsed at cycle 10 -> Busy=0, We never pulses. A following ADD, A=2, B=3 -> Result=5 at 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit execute-stage ALU with registered outputs and a
// Start/Busy/We handshake. Logic, ADD, SUB, SLT and SLTU retire in one cycle.
// DIVU and MODU run on an iterative restoring divider.
// Optional build macro ALU_SEQ_FAST_DIV_EN makes the divider retire two
// quotient bits per cycle. It chains two restoring steps; an odd WIDTH takes
// a single step in its last cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] Result,
  output logic             C,
  output logic             Overflow,
  output logic             Zero,
  output logic             DivZero,
  output logic             Busy,
  output logic             We
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_MODU = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic {IDLE, DIV} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
  } div_st_t;

  // One restoring step. {R,Q} is shifted left by one bit. A trial subtract
  // of D from the shifted remainder sets the next quotient bit.
  function automatic div_st_t div_step(input div_st_t s, input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    div_st_t          o;
    r_sh = {s.r, s.q[WIDTH-1]};
    diff = {1'b0, r_sh} - {2'b00, d};
    o.q  = {s.q[WIDTH-2:0], ~diff[WIDTH+1]};
    o.r  = diff[WIDTH+1] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    return o;
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_step;
  logic [WIDTH-1:0] q, q_nxt, r, r_nxt, d, d_nxt;
  logic             is_mod, mod_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt, ov_nxt, zero_nxt, dz_nxt, we_nxt;

  div_st_t          cur, step_o;

  // Single-cycle datapath signals.
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_ov, legal;

  assign cur = {r, q};

`ifdef ALU_SEQ_FAST_DIV_EN
  div_st_t step_a, step_b;
  logic    two;
  assign step_a   = div_step(cur, d);
  assign step_b   = div_step(step_a, d);
  assign two      = (cnt >= CW'(2));
  assign step_o   = two ? step_b : step_a;
  assign cnt_step = two ? CW'(2) : CW'(1);
`else
  assign step_o   = div_step(cur, d);
  assign cnt_step = CW'(1);
`endif

  // Shared adder and single-cycle result mux. SUB, SLT and SLTU all use A + ~B + 1.
  always_comb begin
    cin     = (ALUOp == OP_SUB) || (ALUOp == OP_SLT) || (ALUOp == OP_SLTU);
    bin     = cin ? ~B : B;
    sum     = {1'b0, A} + {1'b0, bin} + {{WIDTH{1'b0}}, cin};
    ovf     = (A[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ov  = 1'b0;
    legal   = 1'b1;
    case (ALUOp)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      // Sign XOR overflow keeps SLT correct when A-B overflows.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_ov  = ovf;
      end
      default: legal = 1'b0;
    endcase
  end

  // Next state, divider registers and registered outputs. Outputs hold between We pulses.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    r_nxt     = r;
    d_nxt     = d;
    mod_nxt   = is_mod;
    res_nxt   = Result;
    c_nxt     = C;
    ov_nxt    = Overflow;
    zero_nxt  = Zero;
    dz_nxt    = DivZero;
    we_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if ((ALUOp == OP_DIVU) || (ALUOp == OP_MODU)) begin
            if (B == '0) begin
              we_nxt   = 1'b1;
              res_nxt  = (ALUOp == OP_DIVU) ? '1 : A;
              c_nxt    = 1'b0;
              ov_nxt   = 1'b0;
              dz_nxt   = 1'b1;
              zero_nxt = (res_nxt == '0);
            end else begin
              state_nxt = DIV;
              q_nxt     = A;
              d_nxt     = B;
              r_nxt     = '0;
              cnt_nxt   = CW'(WIDTH);
              mod_nxt   = (ALUOp == OP_MODU);
            end
          end else begin
            we_nxt   = 1'b1;
            res_nxt  = alu_res;
            c_nxt    = alu_c;
            ov_nxt   = alu_ov;
            dz_nxt   = 1'b0;
            // An illegal opcode reports every flag as 0, including Zero.
            zero_nxt = legal && (alu_res == '0);
          end
        end
      end
      DIV: begin
        q_nxt   = step_o.q;
        r_nxt   = step_o.r;
        cnt_nxt = cnt - cnt_step;
        if (cnt == cnt_step) begin
          state_nxt = IDLE;
          we_nxt    = 1'b1;
          res_nxt   = is_mod ? step_o.r : step_o.q;
          c_nxt     = 1'b0;
          ov_nxt    = 1'b0;
          dz_nxt    = 1'b0;
          zero_nxt  = (res_nxt == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset wins over Start and aborts any divide.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Divider registers and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= '0;
      q        <= '0;
      r        <= '0;
      d        <= '0;
      is_mod   <= 1'b0;
      Result   <= '0;
      C        <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      DivZero  <= 1'b0;
      Busy     <= 1'b0;
      We       <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      q        <= q_nxt;
      r        <= r_nxt;
      d        <= d_nxt;
      is_mod   <= mod_nxt;
      Result   <= res_nxt;
      C        <= c_nxt;
      Overflow <= ov_nxt;
      Zero     <= zero_nxt;
      DivZero  <= dz_nxt;
      Busy     <= (state_nxt == DIV);
      We       <= we_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table of operations plus hand sequences for reset,
// Start while Busy, Start during the We cycle, and reset aborting a divide.
module tb_alu_seq;

  localparam int W     = 32;
  localparam int LIMIT = 100;
`ifdef ALU_SEQ_FAST_DIV_EN
  localparam int DLAT  = 17;
`else
  localparam int DLAT  = 33;
`endif

  localparam logic [3:0] AND_ = 4'd0, OR_ = 4'd1, XOR_ = 4'd2, NOR_ = 4'd3;
  localparam logic [3:0] SLT_ = 4'd4, ADD_ = 4'd5, SUB_ = 4'd6, MODU_ = 4'd7;
  localparam logic [3:0] DIVU_ = 4'd8, SLTU_ = 4'd9, ILL_ = 4'd10;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   ALUOp = '0;
  logic [W-1:0] Result;
  logic         C, Overflow, Zero, DivZero, Busy, We;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .ALUOp(ALUOp),
    .Result(Result), .C(C), .Overflow(Overflow), .Zero(Zero),
    .DivZero(DivZero), .Busy(Busy), .We(We)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic       c, ov, z, dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts edges up to the We edge.
  task automatic wait_we(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!We && lat < LIMIT) begin
      if (Busy) busy_cycles++;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[$];
  int   lat, bc, wes;

  initial begin
    vecs.push_back('{"add_wrap",  ADD_,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1, 0, 1});
    vecs.push_back('{"add_ovf",   ADD_,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 0, 1});
    vecs.push_back('{"slt_ovf",   SLT_,  32'h80000000, 32'h1,        32'h1,        0, 0, 0, 0, 1});
    vecs.push_back('{"sltu",      SLTU_, 32'h80000000, 32'h1,        32'h0,        0, 0, 1, 0, 1});
    vecs.push_back('{"sltu_lt",   SLTU_, 32'h1,        32'h2,        32'h1,        0, 0, 0, 0, 1});
    vecs.push_back('{"slt_neg",   SLT_,  32'hFFFFFFFF, 32'h0,        32'h1,        0, 0, 0, 0, 1});
    vecs.push_back('{"sub_borrow",SUB_,  32'h5,        32'h7,        32'hFFFFFFFE, 0, 0, 0, 0, 1});
    vecs.push_back('{"sub_ok",    SUB_,  32'h7,        32'h5,        32'h2,        1, 0, 0, 0, 1});
    vecs.push_back('{"sub_ovf",   SUB_,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 1, 0, 0, 1});
    vecs.push_back('{"and",       AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1});
    vecs.push_back('{"or",        OR_,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1});
    vecs.push_back('{"xor",       XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1});
    vecs.push_back('{"nor",       NOR_,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 0, 1});
    vecs.push_back('{"and_zero",  AND_,  32'h0F,       32'hF0,       32'h0,        0, 0, 1, 0, 1});
    vecs.push_back('{"illegal",   ILL_,  32'h5,        32'h3,        32'h0,        0, 0, 0, 0, 1});
    vecs.push_back('{"divu",      DIVU_, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, DLAT});
    vecs.push_back('{"modu",      MODU_, 32'd100,      32'd7,        32'd2,        0, 0, 0, 0, DLAT});
    vecs.push_back('{"divu_b0",   DIVU_, 32'h1234,     32'h0,        32'hFFFFFFFF, 0, 0, 0, 1, 1});
    vecs.push_back('{"modu_b0",   MODU_, 32'h1234,     32'h0,        32'h1234,     0, 0, 0, 1, 1});
    vecs.push_back('{"divu_by1",  DIVU_, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 0, 0, 0, 0, DLAT});
    vecs.push_back('{"divu_small",DIVU_, 32'd5,        32'd9,        32'd0,        0, 0, 1, 0, DLAT});
    vecs.push_back('{"modu_small",MODU_, 32'd5,        32'd9,        32'd5,        0, 0, 0, 0, DLAT});
    vecs.push_back('{"divu_same", DIVU_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, DLAT});

    // Reset held two cycles with Start asserted: nothing may launch.
    Start = 1'b1; ALUOp = ADD_; A = 32'd1; B = 32'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      check("reset_hold", {Result, C, Overflow, Zero, DivZero, Busy, We}, '0);
    end
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clk); #1;
    check("post_reset", {Result, C, Overflow, Zero, DivZero, Busy, We}, '0);

    // Table-driven operations.
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_we(lat, bc);
      check({vecs[i].name, "_out"}, {We, Result, C, Overflow, Zero, DivZero},
            {1'b1, vecs[i].res, vecs[i].c, vecs[i].ov, vecs[i].z, vecs[i].dz});
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
    end

    // Start while Busy is ignored; Busy spans the whole divide.
    start_op(DIVU_, 32'd100, 32'd7);
    repeat (4) begin @(posedge Clk); #1; end
    @(negedge Clk);
    Start = 1'b1; ALUOp = ADD_; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_ignore_state", {Busy, We}, 2'b10);
    wait_we(lat, bc);
    check("busy_ignore_res", {We, Result}, {1'b1, 32'd14});
    check("busy_ignore_lat", lat + 5, DLAT);
    @(posedge Clk); #1;
    check("we_one_cycle", {We, Busy, Result}, {2'b00, 32'd14});
    repeat (2) begin @(posedge Clk); #1; end
    check("result_hold", {We, Result}, {1'b0, 32'd14});

    // Busy count for a fresh divide, then Start during the We cycle.
    start_op(DIVU_, 32'd100, 32'd7);
    wait_we(lat, bc);
    check("busy_cycles", bc, DLAT - 1);
    Start = 1'b1; ALUOp = MODU_; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("we_cycle_start", {Busy, We}, 2'b10);
    wait_we(lat, bc);
    check("we_cycle_res", {We, Result}, {1'b1, 32'd2});
    check("we_cycle_lat", lat, DLAT);

    // Reset during a divide aborts it with no We.
    start_op(DIVU_, 32'd100, 32'd7);
    repeat (9) begin @(posedge Clk); #1; end
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort_state", {Busy, We, Result}, '0);
    @(negedge Clk);
    Reset = 1'b0;
    wes = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (We || Busy) wes++;
    end
    check("abort_no_we", wes, 0);
    start_op(ADD_, 32'd2, 32'd3);
    wait_we(lat, bc);
    check("after_abort_add", {We, Result, C, Overflow, Zero}, {1'b1, 32'd5, 3'b000});
    check("after_abort_lat", lat, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
